shiftreg_universal: RTL and testbench
=====================================

# shiftreg_universal

Parametrised successor to the 16-bit serial-in/parallel-out shift register. Provides a WIDTH-bit universal shift register (hold, shift left, shift right, parallel load) with a word counter that captures each completed WIDTH-bit serial word into an output holding register. The captured word is offered downstream on a valid/ready handshake, with sticky overflow detection. It sits between the serial front end and the ALU operand registers.

## Interface
- WIDTH, 16, register and word width in bits; legal range 2..64.
- reclk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  shift/load enable; low leaves q and cnt unchanged.
- mode  in  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- sin  in  1  serial input bit.
- pin  in  WIDTH  parallel load data.
- rot  in  1  rotate select; present only with SHIFTREG_ROTATE_EN.
- pready  in  1  downstream accepts pout.
- ovf_clr  in  1  clears ovf.
- sout  out  1  serial output: q[WIDTH-1] in mode 01, else q[0]; combinational from q and mode.
- q  out  WIDTH  live shift register contents.
- pout  out  WIDTH  captured word.
- pvalid  out  1  pout holds an unconsumed word.
- ovf  out  1  sticky overflow flag.

## Operation
- Reset (rst_n=0, asynchronous): q=0, cnt=0, pout=0, pvalid=0, ovf=0; sout=0 as a consequence.
- Internal counter cnt, width $clog2(WIDTH), counts shifts in the current word.
- en=1, mode 01: q <= {q[WIDTH-2:0], sin}; cnt increments.
- en=1, mode 10: q <= {sin, q[WIDTH-1:1]}; cnt increments.
- en=1, mode 11: q <= pin; cnt <= 0; no capture.
- mode 00 or en=0: q and cnt hold.
- Word completion: a shift with cnt==WIDTH-1 sets cnt <= 0 (wraps) and produces the post-shift q value as the new word.
- Capture rules on completion:
  - pvalid=0, or pvalid=1 with pready=1: pout <= new word, pvalid <= 1.
  - pvalid=1 with pready=0: the new word is dropped, pout is unchanged, ovf <= 1.
- Without completion, pvalid=1 with pready=1 gives pvalid <= 0 next edge; pout holds its value.
- pready while pvalid=0 is ignored.
- ovf stays set until ovf_clr=1. If a new overflow occurs in the same cycle as ovf_clr, the set wins and ovf stays 1.
- Mixed shift directions within one word are allowed. Every shift is counted.

## Timing
- q updates one edge after the enabled shift or load. sout reflects the new q in the same cycle, with no extra delay.
- pvalid and pout update on the same edge as the WIDTH-th shift; pvalid latency is 0 cycles beyond that edge.
- pout is stable for the whole time pvalid is high.
- Sustained throughput is one word per WIDTH cycles with pready held high. There are no bubbles.
- Reset deassertion must be synchronous to reclk at the integration level. The block assumes no reset synchroniser inside.

## Configuration
- SHIFTREG_ROTATE_EN defined:
  - Adds the rot input.
  - With rot=1, mode 01 feeds q[WIDTH-1] into the LSB and mode 10 feeds q[0] into the MSB; sin is ignored.
  - Rotates count toward word completion like shifts.
- Undefined:
  - The rot port does not exist.
  - Shifts always take sin.

## Test plan
- Reset mid-word: 5 left shifts, then rst_n=0 between edges. q=0, pvalid=0, ovf=0 immediately; next word completes only after 16 further shifts.
- WIDTH=16, mode=01, sin=1, pready=0 for 16 edges. After edge 16: pvalid=1, pout=16'hFFFF, q=16'hFFFF. Before edge 16: pvalid=0.
- Load pin=16'hA5C3 (mode 11), then 16 right shifts with sin=0.
  - sout before each edge: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - No capture after the load; capture after the 16th shift with pout=16'h0000.
- Overflow: word 1 = all ones, then word 2 = all zeros, with pready=0 throughout.
  - After word 2: pout=16'hFFFF, ovf=1.
  - ovf_clr=1 for one cycle gives ovf=0.
- Simultaneous accept and completion: pvalid=1, pready=1 on the 16th shift of the next word. pvalid stays 1, pout = new word, ovf=0.
- SHIFTREG_ROTATE_EN: load 16'h8001, then one mode-01 shift.
  - With rot=1: q=16'h0003.
  - Same with the macro undefined and sin=0: q=16'h0002.

Source files
------------

// File: rtl/shiftreg_universal.sv
// WIDTH-bit universal shift register with word capture on a valid/ready output and sticky overflow.
// Optional feature macro: SHIFTREG_ROTATE_EN adds the rot input (rotate instead of taking sin).
module shiftreg_universal #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             reclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
`ifdef SHIFTREG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             pready,
  input  logic             ovf_clr,
  output logic             sout,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  mode_e            op;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             fill_l;
  logic             fill_r;
  logic             shift;
  logic             done;

  always_comb begin
    op     = mode_e'(mode);
    fill_l = sin;
    fill_r = sin;
`ifdef SHIFTREG_ROTATE_EN
    if (rot) begin
      fill_l = q[WIDTH-1];
      fill_r = q[0];
    end
`endif
    q_nxt   = q;
    cnt_nxt = cnt;
    shift   = 1'b0;
    if (en) begin
      case (op)
        MODE_SHL: begin
          q_nxt = {q[WIDTH-2:0], fill_l};
          shift = 1'b1;
        end
        MODE_SHR: begin
          q_nxt = {fill_r, q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = pin;
          cnt_nxt = '0;
        end
        default: ;
      endcase
    end
    done = shift && (cnt == CNT_LAST);
    if (shift) begin
      cnt_nxt = done ? '0 : cnt + CW'(1);
    end
  end

  assign sout = (op == MODE_SHL) ? q[WIDTH-1] : q[0];

  // A completing word is captured when the slot is free or being drained this edge;
  // otherwise it is dropped and flagged, with the set taking priority over ovf_clr.
  always_ff @(posedge reclk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      cnt    <= '0;
      pout   <= '0;
      pvalid <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
      if (done && (!pvalid || pready)) begin
        pout   <= q_nxt;
        pvalid <= 1'b1;
      end else if (pvalid && pready) begin
        pvalid <= 1'b0;
      end
      if (done && pvalid && !pready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_universal.sv
// Self-checking bench for shiftreg_universal: directed scenarios plus randomized traffic against an arithmetic model.
// Rotate checks are enabled when SHIFTREG_ROTATE_EN is defined for both files.
module tb_shiftreg_universal;

  localparam int unsigned W    = 16;
  localparam longint unsigned MOD  = 64'd1 << W;
  localparam longint unsigned HALF = 64'd1 << (W - 1);

  logic         reclk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         sin;
  logic [W-1:0] pin;
  logic         pready;
  logic         ovf_clr;
  logic         sout;
  logic [W-1:0] q;
  logic [W-1:0] pout;
  logic         pvalid;
  logic         ovf;
`ifdef SHIFTREG_ROTATE_EN
  logic         rot_v;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  // Reference state: register value and word progress as plain numbers.
  longint unsigned m_q = 0;
  longint unsigned m_pout = 0;
  int              m_shifts = 0;
  bit              m_pvalid = 0;
  bit              m_ovf = 0;

  shiftreg_universal #(.WIDTH(W)) dut (
    .reclk  (reclk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .sin    (sin),
    .pin    (pin),
`ifdef SHIFTREG_ROTATE_EN
    .rot    (rot_v),
`endif
    .pready (pready),
    .ovf_clr(ovf_clr),
    .sout   (sout),
    .q      (q),
    .pout   (pout),
    .pvalid (pvalid),
    .ovf    (ovf)
  );

  initial begin
    reclk = 1'b0;
    forever #5 reclk = ~reclk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge reclk or negedge rst_n) begin
    bit              done;
    bit              fill;
    longint unsigned fill_w;
    if (!rst_n) begin
      m_q = 0; m_pout = 0; m_shifts = 0; m_pvalid = 0; m_ovf = 0;
    end else begin
      done = 0;
      if (en && mode == 2'd3) begin
        m_q = pin;
        m_shifts = 0;
      end else if (en && (mode == 2'd1 || mode == 2'd2)) begin
        fill = sin;
`ifdef SHIFTREG_ROTATE_EN
        if (rot_v) fill = (mode == 2'd1) ? (m_q / HALF != 0) : (m_q % 2 != 0);
`endif
        fill_w = fill ? 64'd1 : 64'd0;
        if (mode == 2'd1) m_q = (m_q * 2 + fill_w) % MOD;
        else              m_q = m_q / 2 + fill_w * HALF;
        m_shifts++;
        if (m_shifts == W) begin
          m_shifts = 0;
          done = 1;
        end
      end
      if (ovf_clr) m_ovf = 0;
      if (done) begin
        if (!m_pvalid || pready) begin
          m_pout = m_q;
          m_pvalid = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (m_pvalid && pready) begin
        m_pvalid = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge reclk);
      #1;
      if (chk_on) begin
        chk("q", 64'(q), m_q);
        chk("pout", 64'(pout), m_pout);
        chk("pvalid", 64'(pvalid), 64'(m_pvalid));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("sout", 64'(sout), (mode == 2'd1) ? m_q / HALF : m_q % 2);
      end
    end
  end

  task automatic drive(input logic e, input logic [1:0] md, input logic s,
                       input logic [W-1:0] p, input logic pr, input logic oc);
    @(negedge reclk);
    #1;
    en = e; mode = md; sin = s; pin = p; pready = pr; ovf_clr = oc;
  endtask

  task automatic tick();
    @(posedge reclk);
    #2;
  endtask

  logic [15:0] sout_tbl;

  initial begin
    rst_n = 1'b1;
    en = 0; mode = 0; sin = 0; pin = '0; pready = 0; ovf_clr = 0;
`ifdef SHIFTREG_ROTATE_EN
    rot_v = 0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_pout", 64'(pout), 64'h0);
    chk("rst_pvalid", 64'(pvalid), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_sout", 64'(sout), 64'h0);
    repeat (2) @(negedge reclk);
    #1 rst_n = 1'b1;
    chk_on = 1;

    // Word of ones with the consumer stalled.
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'd1, 1, '0, 0, 0);
      tick();
      if (i < 15) chk("ones_pvalid_early", 64'(pvalid), 64'h0);
    end
    chk("ones_pvalid", 64'(pvalid), 64'h1);
    chk("ones_pout", 64'(pout), 64'hFFFF);
    chk("ones_q", 64'(q), 64'hFFFF);

    // Second word of zeros is dropped.
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'd1, 0, '0, 0, 0);
      tick();
    end
    chk("ovf_pout", 64'(pout), 64'hFFFF);
    chk("ovf_set", 64'(ovf), 64'h1);
    drive(0, 2'd0, 0, '0, 0, 1);
    tick();
    chk("ovf_clr", 64'(ovf), 64'h0);

    // Accept coincides with the completing shift.
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'd1, 1'(i % 2), '0, (i == 15) ? 1'b1 : 1'b0, 0);
      tick();
    end
    chk("acc_pvalid", 64'(pvalid), 64'h1);
    chk("acc_pout", 64'(pout), 64'h5555);
    chk("acc_ovf", 64'(ovf), 64'h0);
    drive(0, 2'd0, 0, '0, 1, 0);
    tick();
    chk("drain_pvalid", 64'(pvalid), 64'h0);

    // Load then shift right, watching sout LSB first.
    drive(1, 2'd3, 0, 16'hA5C3, 0, 0);
    tick();
    chk("load_q", 64'(q), 64'hA5C3);
    chk("load_pvalid", 64'(pvalid), 64'h0);
    sout_tbl = 16'b1010_0101_1100_0011;
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'd2, 0, '0, 0, 0);
      chk("shr_sout", 64'(sout), 64'(sout_tbl[i]));
      tick();
      if (i < 15) chk("shr_pvalid_early", 64'(pvalid), 64'h0);
    end
    chk("shr_pvalid", 64'(pvalid), 64'h1);
    chk("shr_pout", 64'(pout), 64'h0);

    // Left shift of 16'h8001: rotate vs. serial fill.
    drive(1, 2'd3, 0, 16'h8001, 0, 0);
    tick();
`ifdef SHIFTREG_ROTATE_EN
    rot_v = 1;
    drive(1, 2'd1, 0, '0, 0, 0);
    tick();
    chk("rot_q", 64'(q), 64'h0003);
    rot_v = 0;
`else
    drive(1, 2'd1, 0, '0, 0, 0);
    tick();
    chk("norot_q", 64'(q), 64'h0002);
`endif

    // Asynchronous reset in the middle of a word.
    drive(1, 2'd3, 0, '0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd1, 1, '0, 0, 0);
      tick();
    end
    drive(0, 2'd0, 0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 64'(q), 64'h0);
    chk("mid_rst_pvalid", 64'(pvalid), 64'h0);
    chk("mid_rst_ovf", 64'(ovf), 64'h0);
    @(negedge reclk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'd1, 1, '0, 0, 0);
      tick();
      if (i < 15) chk("post_rst_pvalid_early", 64'(pvalid), 64'h0);
    end
    chk("post_rst_pvalid", 64'(pvalid), 64'h1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [1:0]  md;
      r = $urandom_range(0, 9);
      md = (r == 0) ? 2'd0 : (r <= 4) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
`ifdef SHIFTREG_ROTATE_EN
      rot_v = 1'($urandom_range(0, 1));
`endif
      drive(($urandom_range(0, 7) != 0), md, 1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    tick();
    chk_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
